// File: rtl/gpio_display_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment codes and nibble/segment types.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gpio_display_scan_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // Active-low {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam seg_t SEG_OFF = 7'h7F;
  localparam seg_t SEG_0   = 7'h40;
  localparam seg_t SEG_1   = 7'h79;
  localparam seg_t SEG_2   = 7'h24;
  localparam seg_t SEG_3   = 7'h30;
  localparam seg_t SEG_4   = 7'h19;
  localparam seg_t SEG_5   = 7'h12;
  localparam seg_t SEG_6   = 7'h02;
  localparam seg_t SEG_7   = 7'h78;
  localparam seg_t SEG_8   = 7'h00;
  localparam seg_t SEG_9   = 7'h10;
  localparam seg_t SEG_A   = 7'h08;
  localparam seg_t SEG_B   = 7'h03;
  localparam seg_t SEG_C   = 7'h46;
  localparam seg_t SEG_D   = 7'h21;
  localparam seg_t SEG_E   = 7'h06;
  localparam seg_t SEG_F   = 7'h0E;

endpackage

// File: rtl/gpio_display_scan_hex_a_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module hex_a_7seg
  import gpio_display_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for each hex value.
  always_comb begin
    seg_o = SEG_OFF;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/gpio_display_scan.sv
// Scans a per-frame snapshot of valor onto a common-anode multiplexed hex display; optional LEADING_ZERO_BLANK_EN.
// Latency: outputs registered one cycle after the divider/index state; valor visible the frame after its snapshot.
// Backpressure: none; free-running scan, valor sampled only at frame boundaries.
module gpio_display_scan
  import gpio_display_scan_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NUM_DIG-1:0]   valor,
  output logic [NUM_DIG-1:0]     anodos,
  output logic [6:0]             segmentos,
  output logic                   frame_done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] ANO_OFF  = '1;

  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NUM_DIG-1:0] snap_q, snap_d;
  logic [NUM_DIG-1:0]   ano_q, ano_d;
  logic [6:0]           seg_q, seg_d;
  logic                 fd_q, fd_d;

  logic    tick;
  logic    frame_end;
  logic    lz_blank;
  nibble_t cur_nib;
  seg_t    cur_seg;

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // Pick the active digit's nibble; with leading-zero blanking, flag a non-zero
  // position whose nibble and every nibble above it are zero.
  always_comb begin
    logic zero_above;
    cur_nib    = '0;
    lz_blank   = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (snap_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib = snap_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && zero_above) lz_blank = 1'b1;
`endif
      end
    end
  end

  hex_a_7seg u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  // Next state: prescaler, digit index, frame snapshot and registered display drive.
  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    fd_d   = frame_end;
    ano_d  = ANO_OFF;
    seg_d  = SEG_OFF;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (frame_end) snap_d = valor;
    // Anodes stay off for the first BLANK_CYC cycles of each slot so the
    // previous digit's segments never ghost onto the new one.
    if (int'(div_q) >= BLANK_CYC && !lz_blank) begin
      ano_d = ~(NUM_DIG'(1) << idx_q);
      seg_d = cur_seg;
    end
  end

  // State registers with asynchronous active-low reset to the dark display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      ano_q  <= ANO_OFF;
      seg_q  <= SEG_OFF;
      fd_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      ano_q  <= ano_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign anodos     = ano_q;
  assign segmentos  = seg_q;
  assign frame_done = fd_q;

endmodule
